// File: rtl/jk_flip_flop.sv
// Bank of independent positive-edge JK flip-flops with asynchronous active-high reset.
// Q_bar is taken from the same register as Q, so the two outputs are always complementary.
module jk_flip_flop #(
    parameter int unsigned          WIDTH     = 1,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_bar
);

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] next_state;

    // Characteristic equation Q+ = J&~Q | ~K&Q: covers hold, clear, set and toggle per bit.
    always_comb begin
        next_state = (J & ~state) | (~K & state);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= RESET_VAL;
        end else begin
            state <= next_state;
        end
    end

    assign Q     = state;
    assign Q_bar = ~state;

endmodule

// File: tb/tb_jk_flip_flop.sv
// Directed test of jk_flip_flop: single-bit default instance and a 4-bit bank with RESET_VAL=4'b1010.
`timescale 1ns/1ps
module tb_jk_flip_flop;

    logic       clk = 1'b0;
    logic       rst;
    logic       j;
    logic       k;
    logic       q;
    logic       q_bar;

    logic       rst_b;
    logic [3:0] j_b;
    logic [3:0] k_b;
    logic [3:0] q_b;
    logic [3:0] q_bar_b;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    jk_flip_flop dut_bit (
        .Clk   (clk),
        .Reset (rst),
        .J     (j),
        .K     (k),
        .Q     (q),
        .Q_bar (q_bar)
    );

    jk_flip_flop #(
        .WIDTH     (4),
        .RESET_VAL (4'b1010)
    ) dut_bank (
        .Clk   (clk),
        .Reset (rst_b),
        .J     (j_b),
        .K     (k_b),
        .Q     (q_b),
        .Q_bar (q_bar_b)
    );

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_bit(input string tag, input logic exp_q);
        check({tag, ".q"},     {3'b0, q},     {3'b0, exp_q});
        check({tag, ".q_bar"}, {3'b0, q_bar}, {3'b0, ~exp_q});
    endtask

    // Present j/k, wait for the next rising edge, sample 1 ns later.
    task automatic step(input string tag, input logic jj, input logic kk, input logic exp_q);
        j = jj;
        k = kk;
        @(posedge clk);
        #1;
        check_bit(tag, exp_q);
    endtask

    task automatic step_bank(input string tag, input logic [3:0] jj, input logic [3:0] kk,
                             input logic [3:0] exp_q);
        j_b = jj;
        k_b = kk;
        @(posedge clk);
        #1;
        check({tag, ".q"},     q_b,     exp_q);
        check({tag, ".q_bar"}, q_bar_b, ~exp_q);
    endtask

    initial begin
        #5000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b0;
        j     = 1'b0;
        k     = 1'b0;
        rst_b = 1'b1;
        j_b   = '0;
        k_b   = '0;

        // Async reset asserted between edges
        #10;
        rst = 1'b1;
        #1;
        check_bit("async_rst", 1'b0);
        j = 1'b1;
        k = 1'b0;
        #5;  // t=16, edge at 15 passed with J=1 while in reset
        check_bit("rst_hold", 1'b0);
        #4;  // t=20
        rst = 1'b0;

        // Truth table sweep
        step("tt_00", 1'b0, 1'b0, 1'b0);
        step("tt_01", 1'b0, 1'b1, 1'b0);
        step("tt_10", 1'b1, 1'b0, 1'b1);
        step("tt_11", 1'b1, 1'b1, 1'b0);
        step("tt_00b", 1'b0, 1'b0, 1'b0);

        // Toggle run from 0
        step("tog1", 1'b1, 1'b1, 1'b1);
        step("tog2", 1'b1, 1'b1, 1'b0);
        step("tog3", 1'b1, 1'b1, 1'b1);
        step("tog4", 1'b1, 1'b1, 1'b0);

        // Set then hold
        step("set", 1'b1, 1'b0, 1'b1);
        step("hold1", 1'b0, 1'b0, 1'b1);
        step("hold2", 1'b0, 1'b0, 1'b1);

        // J/K glitch between edges must not reach Q
        j = 1'b0;
        k = 1'b1;
        #3;
        check_bit("no_comb_path", 1'b1);
        step("hold3", 1'b0, 1'b0, 1'b1);

        // Mid-operation reset with J=K=1 and Q=1
        j = 1'b1;
        k = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_bit("midop_rst", 1'b0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_bit("after_rst_tog", 1'b1);

        // Bank: reset has been high since t=0
        check("bank_rst.q",     q_b,     4'b1010);
        check("bank_rst.q_bar", q_bar_b, 4'b0101);
        #3;
        rst_b = 1'b0;
        // bit3 hold(1), bit2 clear(0), bit1 set(1), bit0 toggle(0->1)
        step_bank("bank_mix",  4'b0011, 4'b0101, 4'b1011);
        step_bank("bank_set",  4'b1111, 4'b0000, 4'b1111);
        step_bank("bank_tog",  4'b1111, 4'b1111, 4'b0000);
        step_bank("bank_tog2", 4'b0101, 4'b0101, 4'b0101);
        step_bank("bank_hold", 4'b0000, 4'b0000, 4'b0101);
        #3;
        rst_b = 1'b1;
        #1;
        check("bank_async.q",     q_b,     4'b1010);
        check("bank_async.q_bar", q_bar_b, 4'b0101);
        #1;
        rst_b = 1'b0;
        step_bank("bank_clr", 4'b0000, 4'b1111, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
